// File: rtl/cpld_bus_pkg.sv
// Shared definitions for the CPLD static register bus initiator.
package cpld_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_TURN   = 3'd5
  } bus_state_e;

  // Host byte address bits that map onto x_fa[14:9].
  localparam int ADDR_HI = 6;
  localparam int ADDR_LO = 1;

  localparam int REQ_AW = 7;
  localparam int BUS_AW = ADDR_HI - ADDR_LO + 1;
  localparam int BUS_DW = 8;

  // Board CPLD register map (host byte addresses).
  localparam logic [REQ_AW-1:0] REG_CFG     = 7'h00;
  localparam logic [REQ_AW-1:0] REG_LED     = 7'h02;
  localparam logic [REQ_AW-1:0] REG_EVB     = 7'h04;
  localparam logic [REQ_AW-1:0] REG_NAND_CS = 7'h06;

  // A phase of N cycles loads N-1; zero-length phases still last one cycle.
  function automatic int unsigned timer_load(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/cpld_bus_timer.sv
// Loadable down counter that paces each bus phase.
module cpld_bus_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/cpld_bus_master.sv
// Single-beat initiator for the flash/CPLD static register bus.
//
// state     | meaning
// ST_IDLE   | waiting for a host request, req_ready high
// ST_SETUP  | chip enable low, address (and write data) settling
// ST_STROBE | x_fwe or x_foe low; read data captured on the last edge
// ST_HOLD   | strobe released, address/data held for the target latch
// ST_DONE   | one-cycle response pulse, chip enable released
// ST_TURN   | after reads only, lets the target release x_fd
module cpld_bus_master
  import cpld_bus_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_TURN  = 2,
  parameter int          CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [REQ_AW-1:0] req_addr,
  input  logic [BUS_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [BUS_DW-1:0] rsp_rdata,
  output logic              busy,
  output logic              x_fce1,
  output logic              x_fwe,
  output logic              x_foe,
  output logic [BUS_AW-1:0] x_fa,
  output logic [BUS_DW-1:0] x_fd_o,
  output logic              x_fd_oe,
  input  logic [BUS_DW-1:0] x_fd_i
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(timer_load(T_SETUP));
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(timer_load(T_PULSE));
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(timer_load(T_HOLD));
  localparam logic [CNT_W-1:0] LD_TURN  = CNT_W'(timer_load(T_TURN));

  bus_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [BUS_AW-1:0] fa_q;
  logic [BUS_DW-1:0] wdata_q, rdata_q;
  logic              fce1_q, fwe_q, foe_q, fd_oe_q, rsp_valid_q;
  logic              fce1_d, fwe_d, foe_d, fd_oe_d, rsp_valid_d;
  logic              accept, capture, bus_active_d;
  logic              tmr_load, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic [CNT_W-1:0]  tmr_value_unused;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = req_addr[0];

  cpld_bus_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value_unused),
    .zero_o     (tmr_zero)
  );

  // Phase sequencing; the timer is reloaded on every timed-phase entry.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        accept   = 1'b1;
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      ST_SETUP: if (tmr_zero) begin
        state_d  = ST_STROBE;
        tmr_load = 1'b1;
        tmr_val  = LD_PULSE;
      end
      ST_STROBE: if (tmr_zero) begin
        capture  = ~wr_q;
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      ST_HOLD: if (tmr_zero) state_d = ST_DONE;
      ST_DONE: begin
        if (!wr_q && (T_TURN != 0)) begin
          state_d  = ST_TURN;
          tmr_load = 1'b1;
          tmr_val  = LD_TURN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: if (tmr_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad strobes are decoded from the next state so they leave a flop glitch-free.
  always_comb begin
    wr_d         = accept ? req_wr : wr_q;
    bus_active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    fce1_d       = ~bus_active_d;
    fwe_d        = ~((state_d == ST_STROBE) && wr_d);
    foe_d        = ~((state_d == ST_STROBE) && !wr_d);
    fd_oe_d      = bus_active_d && wr_d;
    rsp_valid_d  = (state_d == ST_DONE);
  end

  // State, latched request and registered pad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      fa_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      fce1_q      <= 1'b1;
      fwe_q       <= 1'b1;
      foe_q       <= 1'b1;
      fd_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      fce1_q      <= fce1_d;
      fwe_q       <= fwe_d;
      foe_q       <= foe_d;
      fd_oe_q     <= fd_oe_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        fa_q    <= req_addr[ADDR_HI:ADDR_LO];
        rdata_q <= '0;
        if (req_wr) wdata_q <= req_wdata;
      end
      if (capture) rdata_q <= x_fd_i;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign x_fce1    = fce1_q;
  assign x_fwe     = fwe_q;
  assign x_foe     = foe_q;
  assign x_fa      = fa_q;
  assign x_fd_o    = wdata_q;
  assign x_fd_oe   = fd_oe_q;

endmodule

// File: tb/tb_cpld_bus_master.sv
// Bench for cpld_bus_master: a CPLD register-file target on the pins and a
// request-level reference memory predicting every read.
module tb_cpld_bus_master;
  import cpld_bus_pkg::*;

  localparam int TS = 2, TP = 4, TH = 2, TT = 2;

  logic       clk, rst;
  logic       req_valid, req_ready, req_wr, rsp_valid, busy;
  logic [6:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       x_fce1, x_fwe, x_foe, x_fd_oe;
  logic [5:0] x_fa;
  logic [7:0] x_fd_o, x_fd_i;

  logic       f_req_valid, f_req_ready, f_req_wr, f_rsp_valid, f_busy;
  logic [6:0] f_req_addr;
  logic [7:0] f_req_wdata, f_rsp_rdata;
  logic       f_fce1, f_fwe, f_foe, f_fd_oe;
  logic [5:0] f_fa;
  logic [7:0] f_fd_o, f_fd_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tgt_mem [64];
  logic [7:0] ref_mem [64];

  cpld_bus_master #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_TURN(TT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .x_fce1(x_fce1), .x_fwe(x_fwe), .x_foe(x_foe), .x_fa(x_fa),
    .x_fd_o(x_fd_o), .x_fd_oe(x_fd_oe), .x_fd_i(x_fd_i)
  );

  cpld_bus_master #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0), .T_TURN(0), .CNT_W(4)) dut_f (
    .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wr(f_req_wr),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .busy(f_busy), .x_fce1(f_fce1), .x_fwe(f_fwe), .x_foe(f_foe), .x_fa(f_fa),
    .x_fd_o(f_fd_o), .x_fd_oe(f_fd_oe), .x_fd_i(f_fd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target drives its register only while output-enabled; junk otherwise.
  assign x_fd_i = !x_foe ? tgt_mem[x_fa] : 8'h5A;
  assign f_fd_i = !f_foe ? 8'h3C : 8'hC3;

  // Target latches write data on the rising write strobe.
  always @(posedge x_fwe) begin
    if (!rst && !x_fce1 && x_fd_oe) tgt_mem[x_fa] <= x_fd_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("inv_strobe_excl", (!x_fwe && !x_foe), 0);
      chk("inv_strobe_ce", ((!x_fwe || !x_foe) && x_fce1), 0);
      chk("inv_oe_on_read", (x_fd_oe && !x_foe), 0);
    end
  end

  // One transaction on the default-timing instance with a per-cycle waveform check.
  task automatic txn(input logic wr, input logic [6:0] addr, input logic [7:0] wd);
    int s, p, h, d, r, guard;
    logic [7:0] exp_rd;
    s = (TS == 0) ? 1 : TS;
    p = (TP == 0) ? 1 : TP;
    h = (TH == 0) ? 1 : TH;
    d = s + p + h + 1;
    r = wr ? d + 1 : d + 1 + TT;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    exp_rd = wr ? 8'h00 : ref_mem[addr[6:1]];
    if (wr) ref_mem[addr[6:1]] = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wr = $urandom; req_addr = 7'($urandom); req_wdata = 8'($urandom);
    for (int k = 1; k <= r; k++) begin
      @(negedge clk);
      chk("fce1", x_fce1, (k <= s + p + h) ? 0 : 1);
      chk("fwe", x_fwe, (wr && k > s && k <= s + p) ? 0 : 1);
      chk("foe", x_foe, (!wr && k > s && k <= s + p) ? 0 : 1);
      chk("fd_oe", x_fd_oe, (wr && k <= s + p + h) ? 1 : 0);
      chk("fa", x_fa, addr[6:1]);
      if (wr && k <= s + p + h) chk("fd_o", x_fd_o, wd);
      chk("rsp_valid", rsp_valid, (k == d) ? 1 : 0);
      if (k == d) chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("req_ready", req_ready, (k == r) ? 1 : 0);
      chk("busy", busy, (k == r) ? 0 : 1);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [6:0] a;
    logic [6:0] reg_list [4];
    int guard;
    logic saw;

    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      tgt_mem[i] = v;
      ref_mem[i] = v;
    end
    reg_list[0] = REG_CFG; reg_list[1] = REG_LED; reg_list[2] = REG_EVB; reg_list[3] = REG_NAND_CS;
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    f_req_valid = 0; f_req_wr = 0; f_req_addr = 0; f_req_wdata = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_fce1", x_fce1, 1);
    chk("rst_fwe", x_fwe, 1);
    chk("rst_foe", x_foe, 1);
    chk("rst_fa", x_fa, 0);
    chk("rst_fd_o", x_fd_o, 0);
    chk("rst_fd_oe", x_fd_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);

    // Directed write and read
    txn(1'b1, 7'h22, 8'h31);
    tgt_mem[6'h0E] = 8'hA5;
    ref_mem[6'h0E] = 8'hA5;
    txn(1'b0, 7'h1C, 8'h00);

    // Read with a write held pending behind it
    @(negedge clk);
    chk("b2b_ready0", req_ready, 1);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 7'h1C; req_wdata = 8'h00;
    @(posedge clk);
    #1 req_wr = 1'b1; req_addr = 7'h24; req_wdata = 8'h5E;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("b2b_ready", req_ready, (k == 12) ? 1 : 0);
      chk("b2b_fd_oe", x_fd_oe, (k == 13) ? 1 : 0);
      if (k == 9) chk("b2b_rdata", rsp_rdata, 8'hA5);
      if (k == 12) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    ref_mem[6'h12] = 8'h5E;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b_wr_rsp", rsp_valid, 1);

    // Reset in the middle of a write strobe
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 7'h30; req_wdata = 8'hC7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_fwe_low", x_fwe, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_fwe", x_fwe, 1);
    chk("mid_fce1", x_fce1, 1);
    chk("mid_fd_oe", x_fd_oe, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 1);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("mid_no_rsp", saw, 0);
    txn(1'b0, 7'h30, 8'h00);

    // Minimum timing instance, read
    @(negedge clk);
    chk("fast_ready0", f_req_ready, 1);
    f_req_valid = 1'b1; f_req_wr = 1'b0; f_req_addr = 7'h10;
    @(posedge clk);
    #1 f_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("fast_foe", f_foe, (k == 2) ? 0 : 1);
      chk("fast_fce1", f_fce1, (k <= 3) ? 0 : 1);
      chk("fast_fd_oe", f_fd_oe, 0);
      chk("fast_rsp_valid", f_rsp_valid, (k == 4) ? 1 : 0);
      chk("fast_ready", f_req_ready, (k == 5) ? 1 : 0);
      if (k == 4) chk("fast_rdata", f_rsp_rdata, 8'h3C);
    end

    // Random stream against the reference memory
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) a = reg_list[$urandom_range(0, 3)];
      else a = 7'($urandom_range(0, 127));
      txn(1'($urandom_range(0, 1)), a, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
